ifetch_queue: RTL and testbench

- Instruction prefetch queue between the instruction bus and the fetch stage.
- Issues sequential ibus reads with at most one request outstanding.
- Buffers returned {pc, instr} pairs in a DEPTH-entry FIFO that the fetch stage pops with a valid/ready handshake.
- A redirect (branch/jump resolved downstream) flushes the queue and restarts fetch at a new PC, discarding any in-flight response.

---
 rtl/ifetch_queue.sv | 151 +++++++++++++++
 tb/tb_ifetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: walks sequential PCs on the instruction bus
// with a single outstanding request and buffers {pc, instr} pairs for the
// fetch stage. A redirect flushes the buffer and restarts at a new PC.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ireq_valid,
  output logic [63:0]              ireq_addr,
  input  logic                     iresp_data_ok,
  input  logic [31:0]              iresp_data,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [63:0]   next_pc_q, next_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [63:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;

  // A response is kept only for a live request that no redirect has overtaken;
  // a pop in a redirect cycle is swallowed by the flush.
  always_comb begin
    push       = (state_q == REQ) && iresp_data_ok && !redirect_valid;
    pop        = out_valid && out_ready && !redirect_valid;
    count_next = count_q + CW'(push) - CW'(pop);
  end

  // Request sequencing: a new request is launched only when a FIFO slot is
  // guaranteed free for its response, so the buffer can never overflow.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    next_pc_d  = next_pc_q;
    if (redirect_valid) begin
      next_pc_d = redirect_pc & ~64'd3;
    end
    case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_next < DEPTH_C)) begin
          state_d    = REQ;
          req_addr_d = next_pc_q;
          next_pc_d  = next_pc_q + 64'd4;
        end
      end
      REQ: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            state_d = IDLE;
          end else if (count_next < DEPTH_C) begin
            req_addr_d = next_pc_q;
            next_pc_d  = next_pc_q + 64'd4;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (iresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a redirect empties the queue outright.
  always_comb begin
    count_d  = count_next;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control and pointer registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      next_pc_q  <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      next_pc_q  <= next_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset; empty slots are masked at the output.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
      instr_mem_q[wr_ptr_q] <= iresp_data;
    end
  end

  // Slot reservation makes a push into a full queue impossible.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (count_q != DEPTH_C)
        else $error("ifetch_queue: push into full queue");
    end
  end

  assign ireq_valid = (state_q != IDLE);
  assign ireq_addr  = req_addr_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? pc_mem_q[rd_ptr_q]    : 64'd0;
  assign out_instr  = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign count      = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a bus responder with programmable latency, a
// scoreboard of pushed {pc, instr} pairs, a table of streaming phases and
// hand-written redirect / reset sequences.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  // Free-running clock.
  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .count(count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    int cycles;
    int mode;
    int lat;
    bit chk;
    int expCount;
    bit expValid;
  } vec_t;

  ent_t        sb[$];
  vec_t        vecs[5];
  int          errors = 0;
  int          checks = 0;
  int          latency = 0;
  int          waitCnt = 0;
  logic [63:0] expNext = RESET_PC;
  logic [63:0] curAddr = '0;
  logic [63:0] heldAddr;
  bit          discardFlag = 0;
  bit          prevValid = 0;
  bit          prevDataOk = 0;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit isNewReq();
    return ireq_valid && (!prevValid || prevDataOk);
  endfunction

  // One clock cycle, entered and left at a negedge: check the registered
  // outputs, respond as the bus, update the scoreboard, then drive inputs.
  task automatic applyStimulus(input bit ready, input bit redir, input logic [63:0] rpc, input bit rst);
    bit   dok;
    ent_t e;
    dok            = 1'b0;
    reset          = rst;
    out_ready      = ready;
    redirect_valid = redir && !rst;
    redirect_pc    = rpc;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    if (!rst) begin
      checkOutput("count", 64'(count), 64'(sb.size()));
      checkOutput("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() == 0) begin
        checkOutput("empty_pc", out_pc, 64'd0);
        checkOutput("empty_instr", 64'(out_instr), 64'd0);
      end
      if (ireq_valid) begin
        if (isNewReq()) begin
          checkOutput("req_addr", ireq_addr, expNext);
          curAddr = ireq_addr;
          expNext = expNext + 64'd4;
          waitCnt = 0;
        end else begin
          checkOutput("req_hold", ireq_addr, curAddr);
        end
        if (waitCnt >= latency) dok = 1'b1;
        else waitCnt++;
      end
      iresp_data_ok = dok;
      iresp_data    = dok ? ireq_addr[31:0] : 32'd0;
      if (out_valid && ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pop_unexpected: got pc %h expected no entry", out_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_instr", 64'(out_instr), 64'(e.instr));
        end
      end
      if (dok) begin
        if (!redirect_valid && !discardFlag) begin
          e.pc    = ireq_addr;
          e.instr = ireq_addr[31:0];
          sb.push_back(e);
        end
        discardFlag = 0;
      end
      if (redirect_valid) begin
        sb.delete();
        expNext = rpc & ~64'd3;
        if (ireq_valid && !dok) discardFlag = 1;
      end
      prevValid  = ireq_valid;
      prevDataOk = dok;
    end else begin
      sb.delete();
      expNext     = RESET_PC;
      discardFlag = 0;
      prevValid   = 0;
      prevDataOk  = 0;
      waitCnt     = 0;
    end
    @(negedge clk);
  endtask

  // Advance at least one cycle, then until a new request appears.
  task automatic waitNewReq(input string name, input logic [63:0] exp);
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 60 && !isNewReq(); i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    if (!isNewReq()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no request expected %h", name, exp);
    end else begin
      checkOutput(name, ireq_addr, exp);
    end
  endtask

  // Advance until a fresh request is visible on the bus (bounded).
  task automatic reachNewReq(input string name);
    for (int i = 0; i < 60 && !isNewReq(); i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    if (!isNewReq()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no request expected one", name);
    end
  endtask

  // Main test sequence.
  initial begin
    vecs[0] = '{cycles: 40, mode: 1, lat: 0, chk: 1, expCount: 1, expValid: 1};
    vecs[1] = '{cycles: 20, mode: 0, lat: 0, chk: 1, expCount: 4, expValid: 0};
    vecs[2] = '{cycles: 60, mode: 2, lat: 1, chk: 0, expCount: 0, expValid: 0};
    vecs[3] = '{cycles: 30, mode: 0, lat: 1, chk: 1, expCount: 4, expValid: 0};
    vecs[4] = '{cycles: 30, mode: 1, lat: 0, chk: 1, expCount: 3, expValid: 1};

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("rst_ireq_addr", ireq_addr, 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);

    latency = 0;
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("first_req_valid", 64'(ireq_valid), 64'd1);
    checkOutput("first_req_addr", ireq_addr, RESET_PC);

    for (int v = 0; v < 5; v++) begin
      latency = vecs[v].lat;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        applyStimulus(vecs[v].mode == 2 ? 1'($urandom_range(0, 1)) : 1'(vecs[v].mode),
                      1'b0, 64'd0, 1'b0);
      end
      if (vecs[v].chk) begin
        checkOutput("vec_count", 64'(count), 64'(vecs[v].expCount));
        checkOutput("vec_ireq_valid", 64'(ireq_valid), 64'(vecs[v].expValid));
      end
    end

    // Full queue: a single pop frees one slot and launches one request.
    latency = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_idle", 64'(ireq_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("pop_one_count", 64'(count), 64'd3);
    checkOutput("pop_one_req", 64'(ireq_valid), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("refill_count", 64'(count), 64'd4);

    // Redirect while a slow request is outstanding: enter DISCARD.
    latency = 3;
    reachNewReq("discard_setup");
    heldAddr = ireq_addr;
    applyStimulus(1'b1, 1'b1, 64'h8000_0102, 1'b0);
    checkOutput("redir_count", 64'(count), 64'd0);
    checkOutput("redir_hold_valid", 64'(ireq_valid), 64'd1);
    checkOutput("redir_hold_addr", ireq_addr, heldAddr);
    waitNewReq("redir_next_addr", 64'h8000_0100);

    // Redirect coinciding with data_ok: no DISCARD, straight to IDLE.
    latency = 0;
    reachNewReq("dok_redir_setup");
    applyStimulus(1'b1, 1'b1, 64'h8000_0200, 1'b0);
    checkOutput("dok_redir_idle", 64'(ireq_valid), 64'd0);
    waitNewReq("dok_redir_addr", 64'h8000_0200);

    // Second redirect during DISCARD wins.
    latency = 3;
    reachNewReq("double_redir_setup");
    applyStimulus(1'b1, 1'b1, 64'h8000_0280, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h8000_0300, 1'b0);
    waitNewReq("double_redir_addr", 64'h8000_0300);

    // PC wrap at the top of the 64-bit space.
    latency = 0;
    reachNewReq("wrap_setup");
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    waitNewReq("wrap_top_addr", 64'hFFFF_FFFF_FFFF_FFFC);
    waitNewReq("wrap_zero_addr", 64'd0);

    // Reset with a request outstanding.
    latency = 3;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    reachNewReq("reset_setup");
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
    checkOutput("mid_rst_valid", 64'(ireq_valid), 64'd0);
    checkOutput("mid_rst_count", 64'(count), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    waitNewReq("mid_rst_first_addr", RESET_PC);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
